unidade_controle_mc: RTL and testbench

Parametrised multicycle control FSM for the RV64 multicycle datapath. It is the successor to the fixed-latency control unit.
- Adds a memory ready/timeout handshake on instruction and data accesses.
- Adds logic/immediate ALU ops, sized loads/stores, jal/jalr, and an in-FSM branch decision.
- Adds a sticky trap state for illegal opcodes and memory timeouts.
- Sits between the instruction register decode fields and all datapath load/mux/ALU controls.

---
 rtl/unidade_controle_mc.sv | 184 ++++++++++++++++++
 tb/tb_unidade_controle_mc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_mc.sv
// rtl/unidade_controle_mc.sv - multicycle RV64 control FSM with memory handshake, timeout and sticky trap
// Optional macro: UNIDADE_CONTROLE_BRANCH_EXT_EN enables blt/bge/bltu/bgeu.
module unidade_controle_mc #(
    parameter int MEM_TIMEOUT = 15,
    parameter int STATE_W     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         OPcode,
    input  logic [2:0]         func3,
    input  logic [6:0]         func7,
    input  logic               mem_ready,
    input  logic               alu_zero,
    input  logic               alu_lt,
    output logic [STATE_W-1:0] stateout,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [1:0]         mem_size,
    output logic               LoadIR,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               LoadRegA,
    output logic               LoadRegB,
    output logic               LoadAOut,
    output logic               LoadMDR,
    output logic [1:0]         MemToReg,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUFct,
    output logic [1:0]         PCSource,
    output logic               trap,
    output logic [1:0]         trap_cause
);
    typedef enum logic [STATE_W-1:0] {
        S_INIT   = STATE_W'(0),  S_FETCH  = STATE_W'(1),  S_DECODE = STATE_W'(2),
        S_ADDR   = STATE_W'(3),  S_MEM_RD = STATE_W'(4),  S_MEM_WB = STATE_W'(5),
        S_MEM_WR = STATE_W'(6),  S_EXE_R  = STATE_W'(7),  S_EXE_I  = STATE_W'(8),
        S_WB_ALU = STATE_W'(9),  S_BRANCH = STATE_W'(10), S_JAL    = STATE_W'(11),
        S_JALR   = STATE_W'(12), S_LUI    = STATE_W'(13), S_TRAP   = STATE_W'(15)
    } state_t;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

    state_t     state, next_state;
    logic [7:0] cnt;
    logic       trap_r;
    logic [1:0] cause_r;
    logic       alu_f3_ok, r_ok, br_ok, taken, timeout;

    assign alu_f3_ok = (func3 == 3'b000) || (func3 == 3'b111) || (func3 == 3'b110) ||
                       (func3 == 3'b100) || (func3 == 3'b010);
    assign r_ok      = ((func7 == 7'b0000000) && alu_f3_ok) ||
                       ((func7 == 7'b0100000) && (func3 == 3'b000));
    assign timeout   = !mem_ready && (cnt == 8'(MEM_TIMEOUT - 1));

`ifdef UNIDADE_CONTROLE_BRANCH_EXT_EN
    assign br_ok = (func3 != 3'b010) && (func3 != 3'b011);
`else
    assign br_ok = (func3[2:1] == 2'b00);
`endif

    // Odd func3 encodings are the inverted sense of the even ones.
    always_comb begin
        taken = 1'b0;
        case (func3[2:1])
            2'b00:   taken = alu_zero ^ func3[0];
            2'b10,
            2'b11:   taken = alu_lt ^ func3[0];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state = S_INIT;
        case (state)
            S_INIT:   next_state = S_FETCH;
            S_FETCH:  next_state = mem_ready ? S_DECODE : (timeout ? S_TRAP : S_FETCH);
            S_DECODE: begin
                case (OPcode)
                    OP_R:    next_state = r_ok ? S_EXE_R : S_TRAP;
                    OP_I:    next_state = alu_f3_ok ? S_EXE_I : S_TRAP;
                    OP_LD,
                    OP_ST:   next_state = func3[2] ? S_TRAP : S_ADDR;
                    OP_BR:   next_state = br_ok ? S_BRANCH : S_TRAP;
                    OP_JAL:  next_state = S_JAL;
                    OP_JALR: next_state = (func3 == 3'b000) ? S_JALR : S_TRAP;
                    OP_LUI:  next_state = S_LUI;
                    default: next_state = S_TRAP;
                endcase
            end
            S_ADDR:   next_state = (OPcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: next_state = mem_ready ? S_MEM_WB : (timeout ? S_TRAP : S_MEM_RD);
            S_MEM_WR: next_state = mem_ready ? S_FETCH : (timeout ? S_TRAP : S_MEM_WR);
            S_EXE_R, S_EXE_I: next_state = S_WB_ALU;
            S_MEM_WB, S_WB_ALU, S_BRANCH, S_JAL, S_JALR, S_LUI: next_state = S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_INIT;
            cnt     <= 8'd0;
            trap_r  <= 1'b0;
            cause_r <= 2'b00;
        end else begin
            state <= next_state;
            // Any state change restarts the wait count for the next memory state.
            if (next_state != state)
                cnt <= 8'd0;
            else if ((state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR) && !mem_ready)
                cnt <= cnt + 8'd1;
            if (next_state == S_TRAP && state != S_TRAP) begin
                trap_r  <= 1'b1;
                cause_r <= (state == S_DECODE) ? 2'b01 : 2'b10;
            end
        end
    end

    assign stateout   = state;
    assign trap       = trap_r;
    assign trap_cause = cause_r;

    always_comb begin
        mem_rd = 1'b0; mem_wr = 1'b0; mem_size = 2'b00;
        LoadIR = 1'b0; PCWrite = 1'b0; RegWrite = 1'b0;
        LoadRegA = 1'b0; LoadRegB = 1'b0; LoadAOut = 1'b0; LoadMDR = 1'b0;
        MemToReg = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUFct = 3'b000; PCSource = 2'b00;
        case (state)
            S_FETCH: begin
                mem_rd = 1'b1; ALUSrcB = 2'b01; ALUFct = 3'b001;
                LoadIR = mem_ready; PCWrite = mem_ready;
            end
            S_DECODE: begin
                LoadRegA = 1'b1; LoadRegB = 1'b1; LoadAOut = 1'b1;
                ALUSrcB = 2'b11; ALUFct = 3'b001;
            end
            S_ADDR: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUFct = 3'b001; LoadAOut = 1'b1;
            end
            S_MEM_RD: begin
                mem_rd = 1'b1; mem_size = func3[1:0]; LoadMDR = mem_ready;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1; MemToReg = 2'b01;
            end
            S_MEM_WR: begin
                mem_wr = 1'b1; mem_size = func3[1:0];
            end
            S_EXE_R, S_EXE_I: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = (state == S_EXE_I) ? 2'b10 : 2'b00;
                LoadAOut = 1'b1;
                case (func3)
                    3'b000:  ALUFct = (state == S_EXE_R && func7 == 7'b0100000) ? 3'b010 : 3'b001;
                    3'b111:  ALUFct = 3'b011;
                    3'b110:  ALUFct = 3'b100;
                    3'b100:  ALUFct = 3'b101;
                    3'b010:  ALUFct = 3'b111;
                    default: ALUFct = 3'b001;
                endcase
            end
            S_WB_ALU: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 2'b01; PCSource = 2'b01; PCWrite = taken;
                ALUFct  = (func3[2:1] == 2'b11) ? 3'b110 : 3'b010;
            end
            S_JAL: begin
                RegWrite = 1'b1; MemToReg = 2'b11; PCWrite = 1'b1; PCSource = 2'b01;
            end
            S_JALR: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUFct = 3'b001; PCSource = 2'b10;
                PCWrite = 1'b1; RegWrite = 1'b1; MemToReg = 2'b11;
            end
            S_LUI: begin
                RegWrite = 1'b1; MemToReg = 2'b10;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_unidade_controle_mc.sv
// tb/tb_unidade_controle_mc.sv - directed-vector bench for unidade_controle_mc
module tb_unidade_controle_mc;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] OPcode = 7'd0;
    logic [2:0] func3 = 3'd0;
    logic [6:0] func7 = 7'd0;
    logic       mem_ready = 1'b0, alu_zero = 1'b0, alu_lt = 1'b0;
    logic [4:0] stateout;
    logic       mem_rd, mem_wr, LoadIR, PCWrite, RegWrite, LoadRegA, LoadRegB, LoadAOut, LoadMDR, trap;
    logic [1:0] mem_size, MemToReg, ALUSrcA, ALUSrcB, PCSource, trap_cause;
    logic [2:0] ALUFct;
    int         checks = 0, errors = 0;

    unidade_controle_mc #(.MEM_TIMEOUT(4), .STATE_W(5)) dut (
        .clk(clk), .reset(reset), .OPcode(OPcode), .func3(func3), .func7(func7),
        .mem_ready(mem_ready), .alu_zero(alu_zero), .alu_lt(alu_lt), .stateout(stateout),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size), .LoadIR(LoadIR),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .LoadRegA(LoadRegA), .LoadRegB(LoadRegB),
        .LoadAOut(LoadAOut), .LoadMDR(LoadMDR), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUFct(ALUFct), .PCSource(PCSource), .trap(trap),
        .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    // All outputs except stateout, packed for whole-vector comparisons.
    wire [24:0] outs = {mem_rd, mem_wr, mem_size, LoadIR, PCWrite, RegWrite, LoadRegA, LoadRegB,
                        LoadAOut, LoadMDR, MemToReg, ALUSrcA, ALUSrcB, ALUFct, PCSource, trap, trap_cause};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        OPcode = op; func3 = f3; func7 = f7;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        check("reset_state", stateout, 0);
        check("reset_outs", outs, 0);

        // add
        mem_ready = 1'b1;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        tick();
        check("fetch_state", stateout, 1);
        check("fetch_ctl", {mem_rd, LoadIR, PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUFct},
              {1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 3'b001});
        tick();
        check("decode_state", stateout, 2);
        check("decode_ctl", {LoadRegA, LoadRegB, LoadAOut, ALUSrcB, ALUFct, RegWrite},
              {3'b111, 2'b11, 3'b001, 1'b0});
        tick();
        check("add_exe_state", stateout, 7);
        check("add_exe_ctl", {ALUSrcA, ALUSrcB, ALUFct, LoadAOut, RegWrite},
              {2'b01, 2'b00, 3'b001, 1'b1, 1'b0});
        tick();
        check("add_wb_state", stateout, 9);
        check("add_wb_ctl", {RegWrite, MemToReg}, {1'b1, 2'b00});
        tick();
        check("add_back_fetch", stateout, 1);

        // sub
        set_instr(7'b0110011, 3'b000, 7'b0100000);
        tick(); tick();
        check("sub_exe", {stateout, ALUFct}, {5'd7, 3'b010});
        tick(); tick();

        // xori
        set_instr(7'b0010011, 3'b100, 7'b0000000);
        tick(); tick();
        check("xori_exe", {stateout, ALUSrcB, ALUFct}, {5'd8, 2'b10, 3'b101});
        tick(); tick();

        // ld with three wait cycles; fourth cycle arrives at the timeout boundary
        set_instr(7'b0000011, 3'b011, 7'b0000000);
        tick(); tick();
        check("ld_addr", {stateout, ALUSrcA, ALUSrcB, ALUFct, LoadAOut}, {5'd3, 2'b01, 2'b10, 3'b001, 1'b1});
        mem_ready = 1'b0;
        tick();
        check("ld_wait1", {stateout, mem_rd, mem_size, LoadMDR}, {5'd4, 1'b1, 2'b11, 1'b0});
        tick();
        check("ld_wait2", {stateout, LoadMDR}, {5'd4, 1'b0});
        tick();
        check("ld_wait3", {stateout, LoadMDR}, {5'd4, 1'b0});
        tick();
        mem_ready = 1'b1;
        #1;
        check("ld_ready", {stateout, LoadMDR, trap}, {5'd4, 1'b1, 1'b0});
        tick();
        check("ld_wb", {stateout, RegWrite, MemToReg, LoadMDR}, {5'd5, 1'b1, 2'b01, 1'b0});
        tick();
        check("ld_back_fetch", stateout, 1);

        // sw
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        tick(); tick(); tick();
        check("sw_mem", {stateout, mem_wr, mem_rd, mem_size}, {5'd6, 1'b1, 1'b0, 2'b10});
        tick();
        check("sw_back_fetch", stateout, 1);

        // beq / bne
        set_instr(7'b1100011, 3'b000, 7'b0000000);
        alu_zero = 1'b1;
        tick(); tick();
        check("beq_taken", {stateout, PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUFct},
              {5'd10, 1'b1, 2'b01, 2'b01, 2'b00, 3'b010});
        alu_zero = 1'b0;
        #1;
        check("beq_not_taken", PCWrite, 0);
        func3 = 3'b001;
        #1;
        check("bne_taken", PCWrite, 1);
        tick();

        // jal, jalr, lui
        set_instr(7'b1101111, 3'b000, 7'b0000000);
        tick(); tick();
        check("jal", {stateout, RegWrite, MemToReg, PCWrite, PCSource}, {5'd11, 1'b1, 2'b11, 1'b1, 2'b01});
        tick();
        set_instr(7'b1100111, 3'b000, 7'b0000000);
        tick(); tick();
        check("jalr", {stateout, PCSource, PCWrite, RegWrite, MemToReg, ALUSrcB},
              {5'd12, 2'b10, 1'b1, 1'b1, 2'b11, 2'b10});
        tick();
        set_instr(7'b0110111, 3'b000, 7'b0000000);
        tick(); tick();
        check("lui", {stateout, RegWrite, MemToReg}, {5'd13, 1'b1, 2'b10});
        tick();

        // blt
        set_instr(7'b1100011, 3'b100, 7'b0000000);
        alu_lt = 1'b1;
        tick(); tick();
`ifdef UNIDADE_CONTROLE_BRANCH_EXT_EN
        check("blt_taken", {stateout, PCWrite, trap}, {5'd10, 1'b1, 1'b0});
`else
        check("blt_illegal", {stateout, trap, trap_cause}, {5'd15, 1'b1, 2'b01});
`endif
        do_reset();
        check("reset_after_blt", {stateout, trap}, {5'd0, 1'b0});

        // illegal opcode
        set_instr(7'b1111111, 3'b000, 7'b0000000);
        tick(); tick(); tick();
        check("illegal_trap", {stateout, outs}, {5'd15, 22'd0, 1'b1, 2'b01});
        tick(); tick();
        check("illegal_hold", {stateout, trap, trap_cause}, {5'd15, 1'b1, 2'b01});
        do_reset();
        check("reset_clears_trap", {stateout, trap, trap_cause}, {5'd0, 1'b0, 2'b00});

        // fetch timeout
        mem_ready = 1'b0;
        tick();
        check("to_fetch1", {stateout, mem_rd, LoadIR}, {5'd1, 1'b1, 1'b0});
        tick(); tick(); tick();
        check("to_fetch4", {stateout, trap}, {5'd1, 1'b0});
        tick();
        check("to_trap", {stateout, trap, trap_cause, mem_rd}, {5'd15, 1'b1, 2'b10, 1'b0});
        mem_ready = 1'b1;
        tick(); tick();
        check("to_hold", {stateout, trap, trap_cause}, {5'd15, 1'b1, 2'b10});

        // reset mid-access
        do_reset();
        mem_ready = 1'b0;
        tick();
        check("mid_fetch", {stateout, mem_rd}, {5'd1, 1'b1});
        do_reset();
        check("mid_reset", {stateout, mem_rd, mem_wr}, {5'd0, 1'b0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
